// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, instruction-memory and decode handshake signals of the fetch stage
interface fetch_queue_if #(
   parameter int ADDR_W = 8,
   parameter int INST_W = 8
) ();
   logic              i_redirect;
   logic [ADDR_W-1:0] i_redirect_pc;
   logic              o_mem_en;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [INST_W-1:0] i_mem_data;
   logic              o_out_valid;
   logic              i_out_ready;
   logic [INST_W-1:0] o_out_inst;
   logic [ADDR_W-1:0] o_out_pc;
   logic [ADDR_W-1:0] o_out_pc_next;
   modport master (
      output i_redirect, i_redirect_pc, i_mem_data, i_out_ready,
      input  o_mem_en, o_mem_addr, o_out_valid, o_out_inst, o_out_pc, o_out_pc_next
   );
   modport slave (
      input  i_redirect, i_redirect_pc, i_mem_data, i_out_ready,
      output o_mem_en, o_mem_addr, o_out_valid, o_out_inst, o_out_pc, o_out_pc_next
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch into a prefetch FIFO with redirect flush and decode backpressure
module fetch_queue #(
   parameter int                ADDR_W   = 8,
   parameter int                INST_W   = 8,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic         i_clock,
   input logic         i_reset,
   fetch_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [ADDR_W-1:0] r_fpc, r_pc_q;
   logic              r_inflight;
   logic [PW-1:0]     r_head, r_tail;
   logic [CW-1:0]     r_count;
   logic [INST_W-1:0] r_inst [DEPTH];
   logic [ADDR_W-1:0] r_pc [DEPTH];
   logic              w_valid, w_pop, w_push, w_issue, w_en;
   logic [ADDR_W-1:0] w_addr;
   logic [CW:0]       w_occ;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Occupancy counts the in-flight read so a returning response always has a free slot
   always_comb begin
      w_valid = r_count != '0;
      w_pop   = w_valid & bus.i_out_ready;
      w_push  = r_inflight & ~bus.i_redirect;
      w_occ   = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
      w_issue = w_occ < (CW+1)'(DEPTH);
      w_en    = ~i_reset & (bus.i_redirect | w_issue);
      w_addr  = bus.i_redirect ? bus.i_redirect_pc : r_fpc;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_fpc      <= RESET_PC;
         r_pc_q     <= '0;
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_en;
         if (w_en) begin
            r_fpc  <= w_addr + 1'b1;
            r_pc_q <= w_addr;
         end
         if (bus.i_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_tail <= f_inc(r_tail);
            if (w_pop) r_head <= f_inc(r_head);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_inst[r_tail] <= bus.i_mem_data;
         r_pc[r_tail]   <= r_pc_q;
      end
   end

   assign bus.o_mem_en      = w_en;
   assign bus.o_mem_addr    = w_addr;
   assign bus.o_out_valid   = w_valid;
   assign bus.o_out_inst    = w_valid ? r_inst[r_head] : '0;
   assign bus.o_out_pc      = w_valid ? r_pc[r_head] : '0;
   assign bus.o_out_pc_next = w_valid ? r_pc[r_head] + 1'b1 : '0;

   assert property (@(posedge i_clock) disable iff (i_reset) !(w_push && r_count == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of two fetch_queue configurations against a PC-stream model
module tb_fetch_queue;
   logic clk = 1'b0;
   logic rst0, rst1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fetch_queue_if #(.ADDR_W(8), .INST_W(8)) b0 ();
   fetch_queue_if #(.ADDR_W(10), .INST_W(16)) b1 ();

   fetch_queue #(.ADDR_W(8), .INST_W(8), .DEPTH(4), .RESET_PC(8'h00)) u0 (
      .i_clock(clk), .i_reset(rst0), .bus(b0.slave));
   fetch_queue #(.ADDR_W(10), .INST_W(16), .DEPTH(2), .RESET_PC(10'h010)) u1 (
      .i_clock(clk), .i_reset(rst1), .bus(b1.slave));

   always @(posedge clk) begin
      b0.i_mem_data <= b0.o_mem_en ? (b0.o_mem_addr ^ 8'h5A) : 8'($urandom);
      b1.i_mem_data <= b1.o_mem_en ? ({6'b0, b1.o_mem_addr} ^ 16'hC3A5) : 16'($urandom);
   end

   task automatic test_reset;
      rst0 = 1'b1;
      b0.i_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_chk++; if (b0.o_mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", b0.o_mem_en); end
      n_chk++; if (b0.o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", b0.o_out_valid); end
      n_chk++; if (b0.o_out_inst !== 8'h00) begin n_fail++; $display("FAIL reset_inst got %h want 00", b0.o_out_inst); end
      n_chk++; if (b0.o_out_pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", b0.o_out_pc); end
      n_chk++; if (b0.o_out_pc_next !== 8'h00) begin n_fail++; $display("FAIL reset_pc_next got %h want 00", b0.o_out_pc_next); end
      @(negedge clk);
      rst0 = 1'b0;
      #1;
      n_chk++; if (b0.o_mem_en !== 1'b1) begin n_fail++; $display("FAIL release_mem_en got %b want 1", b0.o_mem_en); end
      n_chk++; if (b0.o_mem_addr !== 8'h00) begin n_fail++; $display("FAIL release_mem_addr got %h want 00", b0.o_mem_addr); end
   endtask

   task automatic test_stream;
      logic [7:0] exp, nxt;
      exp = 8'h00;
      @(negedge clk);
      rst0 = 1'b1;
      b0.i_out_ready = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         n_chk++; if (b0.o_out_valid !== (i >= 2)) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b want %b", i, b0.o_out_valid, i >= 2); end
         n_chk++; if (b0.o_mem_en !== 1'b1) begin n_fail++; $display("FAIL stream_mem_en cyc %0d got %b want 1", i, b0.o_mem_en); end
         if (b0.o_out_valid) begin
            nxt = exp + 8'd1;
            n_chk++; if (b0.o_out_pc !== exp) begin n_fail++; $display("FAIL stream_pc got %h want %h", b0.o_out_pc, exp); end
            n_chk++; if (b0.o_out_inst !== (exp ^ 8'h5A)) begin n_fail++; $display("FAIL stream_inst got %h want %h", b0.o_out_inst, exp ^ 8'h5A); end
            n_chk++; if (b0.o_out_pc_next !== nxt) begin n_fail++; $display("FAIL stream_pc_next got %h want %h", b0.o_out_pc_next, nxt); end
            exp = nxt;
         end
      end
   endtask

   task automatic test_backpressure;
      int issues, gap;
      logic [7:0] exp;
      issues = 0;
      @(negedge clk);
      rst0 = 1'b1;
      b0.i_out_ready = 1'b0;
      @(negedge clk);
      rst0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (b0.o_mem_en) issues++;
         if (i >= 4) begin
            n_chk++; if (b0.o_mem_en !== 1'b0) begin n_fail++; $display("FAIL bp_stall_mem_en cyc %0d got %b want 0", i, b0.o_mem_en); end
         end
      end
      n_chk++; if (issues != 4) begin n_fail++; $display("FAIL bp_issue_count got %0d want 4", issues); end
      n_chk++; if (b0.o_out_valid !== 1'b1 || b0.o_out_pc !== 8'h00) begin n_fail++; $display("FAIL bp_head_hold got v%b pc %h want v1 pc 00", b0.o_out_valid, b0.o_out_pc); end
      exp = 8'h00;
      gap = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         b0.i_out_ready = 1'b1;
         #1;
         if (i == 0) begin
            n_chk++; if (b0.o_mem_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume_mem_en got %b want 1", b0.o_mem_en); end
         end
         if (b0.o_out_valid) begin
            n_chk++; if (b0.o_out_pc !== exp) begin n_fail++; $display("FAIL bp_pc got %h want %h", b0.o_out_pc, exp); end
            n_chk++; if (b0.o_out_inst !== (exp ^ 8'h5A)) begin n_fail++; $display("FAIL bp_inst got %h want %h", b0.o_out_inst, exp ^ 8'h5A); end
            exp = exp + 8'd1;
            gap = 0;
         end else gap++;
         n_chk++; if (gap > 1) begin n_fail++; $display("FAIL bp_gap got %0d want <=1", gap); end
      end
      n_chk++; if (exp < 8'd8) begin n_fail++; $display("FAIL bp_delivered got %0d want >=8", exp); end
   endtask

   task automatic test_redirect;
      logic [7:0] exp;
      exp = 8'h00;
      @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         b0.i_out_ready = (i <= 6);
         #1;
         if (b0.o_out_valid) begin
            n_chk++; if (b0.o_out_pc !== exp) begin n_fail++; $display("FAIL redir_pre_pc got %h want %h", b0.o_out_pc, exp); end
            if (b0.i_out_ready) exp = exp + 8'd1;
         end
      end
      @(negedge clk);
      b0.i_redirect = 1'b1;
      b0.i_redirect_pc = 8'h40;
      b0.i_out_ready = 1'b1;
      #1;
      n_chk++; if (b0.o_mem_en !== 1'b1) begin n_fail++; $display("FAIL redir_mem_en got %b want 1", b0.o_mem_en); end
      n_chk++; if (b0.o_mem_addr !== 8'h40) begin n_fail++; $display("FAIL redir_mem_addr got %h want 40", b0.o_mem_addr); end
      n_chk++; if (b0.o_out_valid !== 1'b1 || b0.o_out_pc !== 8'h05) begin n_fail++; $display("FAIL redir_same_pop got v%b pc %h want v1 pc 05", b0.o_out_valid, b0.o_out_pc); end
      @(negedge clk);
      b0.i_redirect = 1'b0;
      #1;
      n_chk++; if (b0.o_out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got %b want 0", b0.o_out_valid); end
      exp = 8'h40;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         n_chk++; if (b0.o_out_valid !== 1'b1 || b0.o_out_pc !== exp) begin n_fail++; $display("FAIL redir_post_pc got v%b pc %h want v1 pc %h", b0.o_out_valid, b0.o_out_pc, exp); end
         n_chk++; if (b0.o_out_inst !== (exp ^ 8'h5A)) begin n_fail++; $display("FAIL redir_post_inst got %h want %h", b0.o_out_inst, exp ^ 8'h5A); end
         exp = exp + 8'd1;
      end
   endtask

   task automatic test_wrap;
      logic [7:0] exp, nxt;
      @(negedge clk);
      b0.i_redirect = 1'b1;
      b0.i_redirect_pc = 8'hFE;
      b0.i_out_ready = 1'b1;
      #1;
      n_chk++; if (b0.o_mem_addr !== 8'hFE) begin n_fail++; $display("FAIL wrap_mem_addr got %h want fe", b0.o_mem_addr); end
      @(negedge clk);
      b0.i_redirect = 1'b0;
      #1;
      n_chk++; if (b0.o_out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_bubble got %b want 0", b0.o_out_valid); end
      exp = 8'hFE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         nxt = exp + 8'd1;
         n_chk++; if (b0.o_out_valid !== 1'b1 || b0.o_out_pc !== exp) begin n_fail++; $display("FAIL wrap_pc got v%b pc %h want v1 pc %h", b0.o_out_valid, b0.o_out_pc, exp); end
         n_chk++; if (b0.o_out_pc_next !== nxt) begin n_fail++; $display("FAIL wrap_pc_next got %h want %h", b0.o_out_pc_next, nxt); end
         exp = nxt;
      end
   endtask

   task automatic test_random;
      logic [9:0] exp, nxt;
      int nready;
      exp = 10'h010;
      nready = 0;
      @(negedge clk);
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (i > 0) @(negedge clk);
         b1.i_out_ready = 1'($urandom_range(0, 1));
         #1;
         if (i >= 2) begin
            n_chk++; if (b1.o_out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_rate cyc %0d got %b want 1", i, b1.o_out_valid); end
            if (b1.i_out_ready) nready++;
         end
         if (b1.o_out_valid) begin
            nxt = exp + 10'd1;
            n_chk++; if (b1.o_out_pc !== exp) begin n_fail++; $display("FAIL rnd_pc got %h want %h", b1.o_out_pc, exp); end
            n_chk++; if (b1.o_out_inst !== ({6'b0, exp} ^ 16'hC3A5)) begin n_fail++; $display("FAIL rnd_inst got %h want %h", b1.o_out_inst, {6'b0, exp} ^ 16'hC3A5); end
            n_chk++; if (b1.o_out_pc_next !== nxt) begin n_fail++; $display("FAIL rnd_pc_next got %h want %h", b1.o_out_pc_next, nxt); end
            if (b1.i_out_ready) exp = nxt;
         end
      end
      n_chk++; if (exp !== 10'(32'h10 + nready)) begin n_fail++; $display("FAIL rnd_delivered got %h want %h", exp, 10'(32'h10 + nready)); end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      b1.i_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      rst1 = 1'b1;
      #1;
      n_chk++; if (b1.o_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", b1.o_out_valid); end
      n_chk++; if (b1.o_mem_en !== 1'b0) begin n_fail++; $display("FAIL areset_mem_en got %b want 0", b1.o_mem_en); end
      n_chk++; if (b1.o_out_pc !== 10'h000) begin n_fail++; $display("FAIL areset_pc got %h want 000", b1.o_out_pc); end
      #1;
      rst1 = 1'b0;
      #1;
      n_chk++; if (b1.o_mem_en !== 1'b1 || b1.o_mem_addr !== 10'h010) begin n_fail++; $display("FAIL areset_restart got en%b addr %h want en1 addr 010", b1.o_mem_en, b1.o_mem_addr); end
      @(negedge clk);
      #1;
      n_chk++; if (b1.o_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_bubble got %b want 0", b1.o_out_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_chk++; if (b1.o_out_valid !== 1'b1 || b1.o_out_pc !== 10'(16 + i)) begin n_fail++; $display("FAIL areset_pc_seq got v%b pc %h want v1 pc %h", b1.o_out_valid, b1.o_out_pc, 10'(16 + i)); end
         n_chk++; if (b1.o_out_inst !== (16'(16 + i) ^ 16'hC3A5)) begin n_fail++; $display("FAIL areset_inst got %h want %h", b1.o_out_inst, 16'(16 + i) ^ 16'hC3A5); end
      end
   endtask

   initial begin
      rst0 = 1'b1;
      rst1 = 1'b1;
      b0.i_redirect = 1'b0;
      b0.i_redirect_pc = '0;
      b0.i_out_ready = 1'b0;
      b1.i_redirect = 1'b0;
      b1.i_redirect_pc = '0;
      b1.i_out_ready = 1'b0;
      test_reset;
      test_stream;
      test_backpressure;
      test_redirect;
      test_wrap;
      test_random;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
